// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - CPU/debug requester and memory-side signal bundle for data_mem_arbiter
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // CPU (pipeline MEM stage) port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;
  // Debug unit port
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;
  // Single-port data memory side
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_write;
  logic              mem_write;
  logic [DATA_W-1:0] mem_data_read;
  logic              busy;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_address, mem_data_write, mem_write,
    input  mem_data_read,
    output busy
  );

  // Requesters and memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_address, mem_data_write, mem_write,
    output mem_data_read,
    input  busy
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - CPU/debug arbiter and IDLE->ISSUE->DONE sequencer for the data memory (option macro: MEM_ARB_RR_EN)
module data_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              win_dbg_q, win_dbg_d;          // 1 = debug port owns the current access
  logic              cpu_ack_q, cpu_ack_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_write_q, mem_data_write_d;
  logic              mem_write_q, mem_write_d;     // doubles as the latched we during ISSUE
  logic              grant_dbg;

`ifdef MEM_ARB_RR_EN
  logic              last_dbg_q, last_dbg_d;       // 1 = debug port was served last

  // Round-robin on ties: the port not served last wins; a lone requester always wins
  always_comb begin
    if (bus.cpu_req && bus.dbg_req) begin
      grant_dbg = ~last_dbg_q;
    end else begin
      grant_dbg = bus.dbg_req;
    end
  end
`else
  // Fixed priority: CPU wins every tie, so the debug port can starve
  always_comb begin
    grant_dbg = ~bus.cpu_req;
  end
`endif

  // Next-state and next-output computation for the three-phase transaction
  always_comb begin
    state_d          = state_q;
    win_dbg_d        = win_dbg_q;
    cpu_ack_d        = 1'b0;
    dbg_ack_d        = 1'b0;
    cpu_rdata_d      = cpu_rdata_q;
    dbg_rdata_d      = dbg_rdata_q;
    mem_address_d    = '0;
    mem_data_write_d = '0;
    mem_write_d      = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_dbg_d       = last_dbg_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.cpu_req || bus.dbg_req) begin
          state_d          = S_ISSUE;
          win_dbg_d        = grant_dbg;
          mem_address_d    = grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
          mem_data_write_d = grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
          mem_write_d      = grant_dbg ? bus.dbg_we    : bus.cpu_we;
`ifdef MEM_ARB_RR_EN
          last_dbg_d       = grant_dbg;
`endif
        end
      end
      S_ISSUE: begin
        // The memory acted on the negedge inside this cycle; read data is valid now
        state_d = S_DONE;
        if (!mem_write_q) begin
          if (win_dbg_q) begin
            dbg_rdata_d = bus.mem_data_read;
          end else begin
            cpu_rdata_d = bus.mem_data_read;
          end
        end
        if (win_dbg_q) begin
          dbg_ack_d = 1'b1;
        end else begin
          cpu_ack_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any transaction without an ack. A write already
  // in ISSUE still lands because mem_* stay driven until the resetting edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      win_dbg_q        <= 1'b0;
      cpu_ack_q        <= 1'b0;
      dbg_ack_q        <= 1'b0;
      cpu_rdata_q      <= '0;
      dbg_rdata_q      <= '0;
      mem_address_q    <= '0;
      mem_data_write_q <= '0;
      mem_write_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_dbg_q       <= 1'b1;
`endif
    end else begin
      state_q          <= state_d;
      win_dbg_q        <= win_dbg_d;
      cpu_ack_q        <= cpu_ack_d;
      dbg_ack_q        <= dbg_ack_d;
      cpu_rdata_q      <= cpu_rdata_d;
      dbg_rdata_q      <= dbg_rdata_d;
      mem_address_q    <= mem_address_d;
      mem_data_write_q <= mem_data_write_d;
      mem_write_q      <= mem_write_d;
`ifdef MEM_ARB_RR_EN
      last_dbg_q       <= last_dbg_d;
`endif
    end
  end

  assign bus.cpu_rdata      = cpu_rdata_q;
  assign bus.cpu_ack        = cpu_ack_q;
  assign bus.cpu_stall      = bus.cpu_req & ~cpu_ack_q;
  assign bus.dbg_rdata      = dbg_rdata_q;
  assign bus.dbg_ack        = dbg_ack_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_data_write = mem_data_write_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - randomized and directed self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];

  data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Single-port memory acting on the negedge, write-then-read
  always @(negedge clock) begin
    if (bus.mem_write === 1'b1) mem[bus.mem_address] = bus.mem_data_write;
    bus.mem_data_read <= mem[bus.mem_address];
  end

  task automatic idle_inputs();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.cpu_req = 1'($urandom_range(0, 1)); bus.cpu_we = 1'($urandom_range(0, 1));
      bus.cpu_addr = ADDR_W'($urandom); bus.cpu_wdata = $urandom;
      bus.dbg_req = 1'($urandom_range(0, 1)); bus.dbg_we = 1'($urandom_range(0, 1));
      bus.dbg_addr = ADDR_W'($urandom); bus.dbg_wdata = $urandom;
      @(negedge clock);
      vectors++;
      if ({bus.cpu_ack, bus.dbg_ack, bus.busy, bus.mem_write} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_ctrl: ack/ack/busy/mem_write got %b want 0000", {bus.cpu_ack, bus.dbg_ack, bus.busy, bus.mem_write});
      end
      vectors++;
      if ({bus.cpu_rdata, bus.dbg_rdata} !== {(2*DATA_W){1'b0}}) begin
        miscompares++;
        $display("FAIL reset_rdata: got %h/%h want 0/0", bus.cpu_rdata, bus.dbg_rdata);
      end
      vectors++;
      if ({bus.mem_address, bus.mem_data_write} !== {(ADDR_W+DATA_W){1'b0}}) begin
        miscompares++;
        $display("FAIL reset_mem_bus: got %h/%h want 0/0", bus.mem_address, bus.mem_data_write);
      end
      vectors++;
      if (bus.cpu_stall !== bus.cpu_req) begin
        miscompares++;
        $display("FAIL reset_stall: got %b want %b", bus.cpu_stall, bus.cpu_req);
      end
    end
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_cpu_write_read();
    logic [DATA_W-1:0] wd;
    wd = 32'hDEADBEEF;
    for (int op = 0; op < 2; op++) begin
      bus.cpu_req = 1'b1; bus.cpu_we = (op == 0); bus.cpu_addr = ADDR_W'(5);
      bus.cpu_wdata = (op == 0) ? wd : $urandom;
      #1;
      vectors++;
      if (bus.cpu_stall !== 1'b1) begin
        miscompares++; $display("FAIL cpu_stall_req op%0d: got %b want 1", op, bus.cpu_stall);
      end
      for (int c = 1; c <= 3; c++) begin
        @(negedge clock);
        vectors++;
        if ({bus.cpu_ack, bus.mem_write, bus.busy, bus.cpu_stall} !== {c == 2, (c == 1) && (op == 0), c < 3, c == 1}) begin
          miscompares++;
          $display("FAIL cpu_seq op%0d c%0d: ack/mw/busy/stall got %b want %b", op, c,
                   {bus.cpu_ack, bus.mem_write, bus.busy, bus.cpu_stall}, {c == 2, (c == 1) && (op == 0), c < 3, c == 1});
        end
        if (c == 1) begin
          vectors++;
          if (bus.mem_address !== ADDR_W'(5)) begin
            miscompares++; $display("FAIL cpu_issue_addr op%0d: got %h want 005", op, bus.mem_address);
          end
          if (op == 0) begin
            vectors++;
            if (bus.mem_data_write !== wd) begin
              miscompares++; $display("FAIL cpu_issue_wdata: got %h want %h", bus.mem_data_write, wd);
            end
          end
        end
        if (c == 2) begin
          if (op == 1) begin
            vectors++;
            if (bus.cpu_rdata !== wd) begin
              miscompares++; $display("FAIL cpu_read_back: got %h want %h", bus.cpu_rdata, wd);
            end
          end
          bus.cpu_req = 1'b0;
        end
        if (c == 3) begin
          vectors++;
          if (bus.mem_address !== '0) begin
            miscompares++; $display("FAIL idle_addr op%0d: got %h want 0", op, bus.mem_address);
          end
        end
      end
    end
    ref_mem[5] = wd;
  endtask

  task automatic test_dbg_read();
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = ADDR_W'(7); bus.dbg_wdata = $urandom;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      vectors++;
      if ({bus.dbg_ack, bus.cpu_ack, bus.mem_write} !== {c == 2, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL dbg_seq c%0d: dbg_ack/cpu_ack/mw got %b want %b", c, {bus.dbg_ack, bus.cpu_ack, bus.mem_write}, {c == 2, 1'b0, 1'b0});
      end
      if (c == 1) begin
        vectors++;
        if (bus.mem_address !== ADDR_W'(7)) begin
          miscompares++; $display("FAIL dbg_issue_addr: got %h want 007", bus.mem_address);
        end
      end
      if (c == 2) begin
        vectors++;
        if (bus.dbg_rdata !== 32'h0000_0007) begin
          miscompares++; $display("FAIL dbg_rdata: got %h want 00000007", bus.dbg_rdata);
        end
        bus.dbg_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_in_issue();
    logic [DATA_W-1:0] wv;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = ADDR_W'(9);
    @(negedge clock);
    vectors++;
    if ({bus.busy, bus.mem_address} !== {1'b1, ADDR_W'(9)}) begin
      miscompares++; $display("FAIL rst_issue_pre: busy/addr got %b/%h want 1/009", bus.busy, bus.mem_address);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    vectors++;
    if ({bus.dbg_ack, bus.busy} !== 2'b00) begin
      miscompares++; $display("FAIL rst_issue_abort: ack/busy got %b want 00", {bus.dbg_ack, bus.busy});
    end
    vectors++;
    if (bus.dbg_rdata !== '0) begin
      miscompares++; $display("FAIL rst_issue_rdata: got %h want 0", bus.dbg_rdata);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      vectors++;
      if ({bus.dbg_ack, bus.busy} !== {c == 2, c < 3}) begin
        miscompares++; $display("FAIL rst_retry c%0d: ack/busy got %b want %b", c, {bus.dbg_ack, bus.busy}, {c == 2, c < 3});
      end
      if (c == 2) begin
        vectors++;
        if (bus.dbg_rdata !== 32'd9) begin
          miscompares++; $display("FAIL rst_retry_rdata: got %h want 00000009", bus.dbg_rdata);
        end
        bus.dbg_req = 1'b0;
      end
    end
    wv = $urandom;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = ADDR_W'(11); bus.cpu_wdata = wv;
    @(negedge clock);
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    vectors++;
    if ({mem[11], bus.cpu_ack} !== {wv, 1'b0}) begin
      miscompares++; $display("FAIL rst_write_lands: mem/ack got %h/%b want %h/0", mem[11], bus.cpu_ack, wv);
    end
    ref_mem[11] = wv;
  endtask

  task automatic test_tie();
    int cpu_left, dbg_left;
    logic [31:0] cmask, dmask;
    for (int sc = 0; sc < 2; sc++) begin
      pulse_reset();
      cpu_left = (sc == 0) ? 1 : 2;
      dbg_left = 1;
`ifdef MEM_ARB_RR_EN
      cmask = (sc == 0) ? 32'h0000_0004 : 32'h0000_0104;
      dmask = (sc == 0) ? 32'h0000_0020 : 32'h0000_0020;
`else
      cmask = (sc == 0) ? 32'h0000_0004 : 32'h0000_0024;
      dmask = (sc == 0) ? 32'h0000_0020 : 32'h0000_0100;
`endif
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = ADDR_W'($urandom_range(1, 100));
      bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = ADDR_W'($urandom_range(1, 100));
      for (int c = 1; c <= 10; c++) begin
        @(negedge clock);
        vectors++;
        if ({bus.cpu_ack, bus.dbg_ack} !== {cmask[c], dmask[c]}) begin
          miscompares++;
          $display("FAIL tie sc%0d c%0d: cpu/dbg ack got %b want %b", sc, c, {bus.cpu_ack, bus.dbg_ack}, {cmask[c], dmask[c]});
        end
        if (bus.cpu_ack === 1'b1) begin cpu_left--; if (cpu_left <= 0) bus.cpu_req = 1'b0; end
        if (bus.dbg_ack === 1'b1) begin dbg_left--; if (dbg_left <= 0) bus.dbg_req = 1'b0; end
      end
      idle_inputs();
    end
  endtask

  task automatic test_starvation();
    int cpu_left, dbg_left;
    logic [31:0] cmask, dmask;
    pulse_reset();
    cpu_left = 5; dbg_left = 5;
`ifdef MEM_ARB_RR_EN
    cmask = 32'h0410_4104; dmask = 32'h2082_0820;
`else
    cmask = 32'h0000_4924; dmask = 32'h2492_0000;
`endif
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = ADDR_W'($urandom_range(1, 100));
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = ADDR_W'($urandom_range(1, 100));
    for (int c = 1; c <= 31; c++) begin
      @(negedge clock);
      vectors++;
      if ({bus.cpu_ack, bus.dbg_ack} !== {cmask[c], dmask[c]}) begin
        miscompares++;
        $display("FAIL starve c%0d: cpu/dbg ack got %b want %b", c, {bus.cpu_ack, bus.dbg_ack}, {cmask[c], dmask[c]});
      end
      if (bus.cpu_ack === 1'b1) begin cpu_left--; if (cpu_left <= 0) bus.cpu_req = 1'b0; end
      if (bus.dbg_ack === 1'b1) begin dbg_left--; if (dbg_left <= 0) bus.dbg_req = 1'b0; end
    end
    idle_inputs();
  endtask

  // Transaction-level reference: one access per 3 cycles, granted per the arbitration rule,
  // acked two cycles after grant, served from a reference copy of memory.
  task automatic test_random();
    logic [DATA_W-1:0] prd, pwd, exp_cr, exp_dr;
    logic [ADDR_W-1:0] paddr;
    bit pv, pdbg, pwe, e_issue, e_done, e_cack, e_dack, pick_dbg;
    int g, next_free;
`ifdef MEM_ARB_RR_EN
    bit last_dbg;
    last_dbg = 1'b1;
`endif
    pulse_reset();
    exp_cr = '0; exp_dr = '0; prd = '0; pwd = '0; paddr = '0;
    pv = 1'b0; pdbg = 1'b0; pwe = 1'b0; g = 0; next_free = 0;
    for (int m = 0; m < 600; m++) begin
      @(negedge clock);
      e_issue = pv && (m == g + 1);
      e_done  = pv && (m == g + 2);
      e_cack  = e_done && !pdbg;
      e_dack  = e_done && pdbg;
      if (e_done && !pwe) begin
        if (pdbg) exp_dr = prd; else exp_cr = prd;
      end
      vectors++;
      if ({bus.cpu_ack, bus.dbg_ack, bus.busy, bus.mem_write} !== {e_cack, e_dack, e_issue || e_done, e_issue && pwe}) begin
        miscompares++;
        $display("FAIL rnd_ctrl m%0d: ack/ack/busy/mw got %b want %b", m,
                 {bus.cpu_ack, bus.dbg_ack, bus.busy, bus.mem_write}, {e_cack, e_dack, e_issue || e_done, e_issue && pwe});
      end
      if (e_issue) begin
        vectors++;
        if (bus.mem_address !== paddr || (pwe && bus.mem_data_write !== pwd)) begin
          miscompares++;
          $display("FAIL rnd_issue m%0d: addr/wdata got %h/%h want %h/%h", m, bus.mem_address, bus.mem_data_write, paddr, pwd);
        end
      end else if (!e_done) begin
        vectors++;
        if (bus.mem_address !== '0) begin
          miscompares++; $display("FAIL rnd_idle_addr m%0d: got %h want 0", m, bus.mem_address);
        end
      end
      vectors++;
      if ({bus.cpu_rdata, bus.dbg_rdata} !== {exp_cr, exp_dr}) begin
        miscompares++;
        $display("FAIL rnd_rdata m%0d: got %h/%h want %h/%h", m, bus.cpu_rdata, bus.dbg_rdata, exp_cr, exp_dr);
      end
      vectors++;
      if (bus.cpu_stall !== (bus.cpu_req && !e_cack)) begin
        miscompares++; $display("FAIL rnd_stall m%0d: got %b want %b", m, bus.cpu_stall, bus.cpu_req && !e_cack);
      end
      if (e_done) pv = 1'b0;
      if (e_cack) bus.cpu_req = 1'b0;
      if (e_dack) bus.dbg_req = 1'b0;
      if (!bus.cpu_req && $urandom_range(0, 2) == 0) begin
        bus.cpu_req = 1'b1; bus.cpu_we = 1'($urandom_range(0, 1)); bus.cpu_wdata = $urandom;
        bus.cpu_addr = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
      end
      if (!bus.dbg_req && $urandom_range(0, 2) == 0) begin
        bus.dbg_req = 1'b1; bus.dbg_we = 1'($urandom_range(0, 1)); bus.dbg_wdata = $urandom;
        bus.dbg_addr = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
      end
      if (m >= next_free && (bus.cpu_req || bus.dbg_req)) begin
`ifdef MEM_ARB_RR_EN
        pick_dbg = (bus.cpu_req && bus.dbg_req) ? !last_dbg : bus.dbg_req;
        last_dbg = pick_dbg;
`else
        pick_dbg = !bus.cpu_req;
`endif
        pv = 1'b1; pdbg = pick_dbg; g = m; next_free = m + 3;
        pwe   = pick_dbg ? bus.dbg_we    : bus.cpu_we;
        paddr = pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
        pwd   = pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        if (pwe) ref_mem[paddr] = pwd;
        else     prd = ref_mem[paddr];
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i]     = DATA_W'(i);
      ref_mem[i] = DATA_W'(i);
    end
    bus.mem_data_read = '0;
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_cpu_write_read();
    test_dbg_read();
    test_reset_in_issue();
    test_tie();
    test_starvation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
